// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the Bluetooth UART transmitter.
package bt_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int DATA_BITS            = 8;
    // Wide enough for bit periods up to 2^20-1 clocks.
    localparam int BIT_CNT_W            = 20;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef logic [DATA_BITS-1:0] tx_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/bt_tx_fifo.sv
// Synchronous byte FIFO; pointers wrap naturally because DEPTH is a power of two.
module bt_tx_fifo
    import bt_uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  tx_byte_t         push_data,
    input  logic             pop,
    output tx_byte_t         pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    tx_byte_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full     = (count_q == CNT_DEPTH);
        empty    = (count_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/bt_uart_tx.sv
// 8N1 UART transmitter for the Bluetooth module link, fed from a small byte FIFO.
//   state    | meaning
//   ST_IDLE  | line high, waiting for a buffered byte
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | stop bit (high); chains straight into ST_START if more bytes wait
module bt_uart_tx
    import bt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        Tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BIDX_W = $clog2(DATA_BITS);

    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ONE  = 1;
    localparam logic [BIDX_W-1:0]    BIDX_LAST    = BIDX_W'(DATA_BITS - 1);
    localparam logic [BIDX_W-1:0]    BIDX_ONE     = 1;
    localparam logic [CNT_W-1:0]     CNT_DEPTH    = CNT_W'(FIFO_DEPTH);

    tx_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BIDX_W-1:0]    bidx_q, bidx_d;
    tx_byte_t             shift_q, shift_d;
    logic                 tx_q, tx_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    tx_byte_t             fifo_rdata;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 bit_last;

    assign tx_ready  = (fifo_cnt < CNT_DEPTH);
    assign fifo_push = tx_valid && tx_ready;

    bt_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_cnt),
        .empty     (fifo_empty)
    );

    assign bit_last = (cnt_q == BIT_CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                bidx_d = '0;
                tx_d   = STOP_BIT;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    tx_d     = START_BIT;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + BIT_CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (bidx_q == BIDX_LAST) begin
                        bidx_d  = '0;
                        tx_d    = STOP_BIT;
                        state_d = ST_STOP;
                    end else begin
                        bidx_d  = bidx_q + BIDX_ONE;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + BIT_CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    cnt_d = '0;
                    // Chaining here avoids any idle gap between back-to-back frames.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = START_BIT;
                        state_d  = ST_START;
                    end else begin
                        tx_d    = STOP_BIT;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + BIT_CNT_ONE;
                end
            end
            default: begin
                tx_d    = STOP_BIT;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign Tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) || (fifo_cnt != '0);
    assign fifo_count = fifo_cnt;

endmodule
